// File: rtl/cpu_controller.sv
// cpu_controller: 4-bit micro-sequenced datapath.
// A 3-bit program counter steps through a hard-wired 8-word control ROM.
// Each control word drives a 2:1 source mux, a 4-bit accumulator and a 4-bit ALU.
//
// Control word: [3] reg_we, [2] mux_sel (0 = mux_in_data, 1 = alu_out),
//               [1:0] alu_op (00 ADD, 01 SUB, 10 AND, 11 XOR)
//
// Build option: define CPU_HALT_EN to make the PC stop at 7 instead of
// wrapping. The trailing NOP words then hold the register until reset.
//
// Ports:
//   clk          in   clock, rising edge
//   rstn         in   asynchronous active-low reset
//   mux_in_data  in   [3:0] external load operand (mux source 0)
//   alu_in_data  in   [3:0] ALU B operand
//   pc_out       out  [2:0] program counter
//   rom_out      out  [3:0] control word at ROM[pc_out] (combinational)
//   reg_out      out  [3:0] accumulator
//   alu_out      out  [3:0] ALU result (combinational)
//   carry_out    out  ALU carry; on SUB, 1 means no borrow (combinational)

module cpu_pc (
  input  logic       clk,
  input  logic       rstn,
  output logic [2:0] pc_out
);
  logic [2:0] pc_q;
  logic [2:0] pc_d;

  always_comb begin
`ifdef CPU_HALT_EN
    pc_d = (pc_q == 3'd7) ? pc_q : pc_q + 3'd1;
`else
    pc_d = pc_q + 3'd1;  // 7 -> 0 wrap comes from the 3-bit overflow
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pc_q <= 3'd0;
    else       pc_q <= pc_d;
  end

  assign pc_out = pc_q;
endmodule

module cpu_rom (
  input  logic [2:0] addr,
  output logic [3:0] word
);
  always_comb begin
    word = 4'b0000;
    case (addr)
      3'd0:    word = 4'b1000;  // LOAD
      3'd1:    word = 4'b1100;  // ADD
      3'd2:    word = 4'b1100;  // ADD
      3'd3:    word = 4'b1101;  // SUB
      3'd4:    word = 4'b1111;  // XOR
      3'd5:    word = 4'b1110;  // AND
      default: word = 4'b0000;  // NOP
    endcase
  end
endmodule

module cpu_mux (
  input  logic       sel,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  output logic [3:0] out
);
  assign out = sel ? in1 : in0;
endmodule

module cpu_reg (
  input  logic       clk,
  input  logic       rstn,
  input  logic       we,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] reg_q;
  logic [3:0] reg_d;

  assign reg_d = we ? d : reg_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) reg_q <= 4'd0;
    else       reg_q <= reg_d;
  end

  assign q = reg_q;
endmodule

module cpu_alu (
  input  logic [1:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y,
  output logic       carry
);
  logic [4:0] sum;

  always_comb begin
    sum = 5'd0;
    case (op)
      2'b00:   sum = {1'b0, a} + {1'b0, b};
      2'b01:   sum = {1'b0, a} + {1'b0, ~b} + 5'd1;  // carry set = no borrow
      2'b10:   sum = {1'b0, a & b};
      default: sum = {1'b0, a ^ b};
    endcase
  end

  assign y     = sum[3:0];
  assign carry = sum[4];
endmodule

module cpu_controller (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] mux_in_data,
  input  logic [3:0] alu_in_data,
  output logic [2:0] pc_out,
  output logic [3:0] rom_out,
  output logic [3:0] reg_out,
  output logic [3:0] alu_out,
  output logic       carry_out
);
  logic [3:0] reg_in;

  cpu_pc u_pc (
    .clk    (clk),
    .rstn   (rstn),
    .pc_out (pc_out)
  );

  cpu_rom u_rom (
    .addr (pc_out),
    .word (rom_out)
  );

  cpu_mux u_mux (
    .sel (rom_out[2]),
    .in0 (mux_in_data),
    .in1 (alu_out),
    .out (reg_in)
  );

  cpu_reg u_reg (
    .clk  (clk),
    .rstn (rstn),
    .we   (rom_out[3]),
    .d    (reg_in),
    .q    (reg_out)
  );

  cpu_alu u_alu (
    .op    (rom_out[1:0]),
    .a     (reg_out),
    .b     (alu_in_data),
    .y     (alu_out),
    .carry (carry_out)
  );
endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;
  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] mux_in_data;
  logic [3:0] alu_in_data;
  logic [2:0] pc_out;
  logic [3:0] rom_out;
  logic [3:0] reg_out;
  logic [3:0] alu_out;
  logic       carry_out;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    string      tag;
    logic [2:0] pc;
    logic [3:0] rom;
    logic [3:0] rg;
    logic [3:0] alu;
    logic       carry;
  } exp_t;

  exp_t sb[$];

  cpu_controller dut (
    .clk         (clk),
    .rstn        (rstn),
    .mux_in_data (mux_in_data),
    .alu_in_data (alu_in_data),
    .pc_out      (pc_out),
    .rom_out     (rom_out),
    .reg_out     (reg_out),
    .alu_out     (alu_out),
    .carry_out   (carry_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic expect_state(input string tag, input logic [2:0] pc, input logic [3:0] rom,
                              input logic [3:0] rg, input logic [3:0] alu, input logic carry);
    exp_t e;
    e.tag = tag; e.pc = pc; e.rom = rom; e.rg = rg; e.alu = alu; e.carry = carry;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard_empty: observed nothing queued, expected an entry");
      return;
    end
    e = sb.pop_front();
    tests++;
    assert (pc_out === e.pc) else begin
      failed++;
      $error("FAIL %s.pc observed=%0d expected=%0d", e.tag, pc_out, e.pc);
    end
    tests++;
    assert (rom_out === e.rom) else begin
      failed++;
      $error("FAIL %s.rom observed=%b expected=%b", e.tag, rom_out, e.rom);
    end
    tests++;
    assert (reg_out === e.rg) else begin
      failed++;
      $error("FAIL %s.reg observed=%b expected=%b", e.tag, reg_out, e.rg);
    end
    tests++;
    assert (alu_out === e.alu) else begin
      failed++;
      $error("FAIL %s.alu observed=%b expected=%b", e.tag, alu_out, e.alu);
    end
    tests++;
    assert (carry_out === e.carry) else begin
      failed++;
      $error("FAIL %s.carry observed=%b expected=%b", e.tag, carry_out, e.carry);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    mux_in_data = 4'b0000;
    alu_in_data = 4'b0000;
    #2;
    expect_state("reset", 3'd0, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    check_pop();

    // Release away from the edge; the next rising edge executes ROM[0].
    @(negedge clk);
    mux_in_data = 4'b0101;
    alu_in_data = 4'b0001;
    rstn = 1'b1;

    expect_state("e1", 3'd1, 4'b1100, 4'b0101, 4'b0110, 1'b0);
    edge_step(); check_pop();
    expect_state("e2", 3'd2, 4'b1100, 4'b0110, 4'b0111, 1'b0);
    edge_step(); check_pop();
    expect_state("e3", 3'd3, 4'b1101, 4'b0111, 4'b0110, 1'b1);
    edge_step(); check_pop();
    expect_state("e4", 3'd4, 4'b1111, 4'b0110, 4'b0111, 1'b0);
    edge_step(); check_pop();

    // Mid-cycle operand change shows up combinationally.
    alu_in_data = 4'b1000;
    #2;
    expect_state("e4_alu_change", 3'd4, 4'b1111, 4'b0110, 4'b1110, 1'b0);
    check_pop();

    expect_state("e5", 3'd5, 4'b1110, 4'b1110, 4'b1000, 1'b0);
    edge_step(); check_pop();
    expect_state("e6", 3'd6, 4'b0000, 4'b1000, 4'b0000, 1'b1);
    edge_step(); check_pop();
    expect_state("e7", 3'd7, 4'b0000, 4'b1000, 4'b0000, 1'b1);
    edge_step(); check_pop();

`ifdef CPU_HALT_EN
    for (int i = 0; i < 4; i++) begin
      expect_state("halt", 3'd7, 4'b0000, 4'b1000, 4'b0000, 1'b1);
      edge_step(); check_pop();
    end
    rstn = 1'b0;
    mux_in_data = 4'b1111;
    alu_in_data = 4'b0001;
    #2;
    @(negedge clk);
    rstn = 1'b1;
`else
    expect_state("wrap", 3'd0, 4'b1000, 4'b1000, 4'b0000, 1'b1);
    edge_step(); check_pop();
    mux_in_data = 4'b1111;
    alu_in_data = 4'b0001;
    #2;
    expect_state("wrap_in", 3'd0, 4'b1000, 4'b1000, 4'b1001, 1'b0);
    check_pop();
`endif
    expect_state("carry_load", 3'd1, 4'b1100, 4'b1111, 4'b0000, 1'b1);
    edge_step(); check_pop();

    // Mid-run asynchronous reset at pc=3.
    rstn = 1'b0;
    mux_in_data = 4'b0101;
    alu_in_data = 4'b0001;
    #2;
    @(negedge clk);
    rstn = 1'b1;
    edge_step(); edge_step(); edge_step();
    expect_state("pre_abort", 3'd3, 4'b1101, 4'b0111, 4'b0110, 1'b1);
    check_pop();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    expect_state("async_rst", 3'd0, 4'b1000, 4'b0000, 4'b0001, 1'b0);
    check_pop();
    expect_state("held_rst", 3'd0, 4'b1000, 4'b0000, 4'b0001, 1'b0);
    edge_step(); check_pop();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
